serial_deserializer_16bit: RTL and testbench

SERIAL_DESERIALIZER_16BIT -- requirements
Module: serial_deserializer_16bit

---
 rtl/serial_deserializer_16bit_pkg.sv | 26 ++
 rtl/serial_deserializer_16bit_if.sv | 25 ++
 rtl/shift_align_16bit.sv | 15 +
 rtl/serial_deserializer_16bit.sv | 108 ++++++++++
 tb/tb_serial_deserializer_16bit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/serial_deserializer_16bit_pkg.sv
// Shared constants and state encoding for the serial deserializer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_deserializer_16bit_pkg;

   // Maximum frame length in bits and output word width
   localparam int WIDTH   = 16;
   // Width of the frame-length-minus-one field sampled with start
   localparam int AMT_W   = 4;
   // Bit counter width, one extra bit so a 16-bit frame does not wrap
   localparam int CNT_W   = 5;
   // Width of the right-justification shift amount
   localparam int SHAMT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Frame length is amt+1; widen first so amt=15 yields 16, not 0
   function automatic logic [CNT_W-1:0] frame_len(input logic [AMT_W-1:0] amt);
      return {1'b0, amt} + CNT_W'(1);
   endfunction

endpackage

// File: rtl/serial_deserializer_16bit_if.sv
// Handshake and data bundle between a frame source and the deserializer.
// Latency: n/a (wiring only).
// Backpressure: none; sin_valid low simply stalls the frame.
interface serial_deserializer_16bit_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [3:0]       amt;
   logic             choice;
   logic             sin;
   logic             sin_valid;
   logic [WIDTH-1:0] y;
   logic             done;
   logic             busy;

   modport master (
      output start, amt, choice, sin, sin_valid,
      input  y, done, busy
   );

   modport slave (
      input  start, amt, choice, sin, sin_valid,
      output y, done, busy
   );
endinterface

// File: rtl/shift_align_16bit.sv
// Combinational logical right shift used to right-justify LSB-first frames.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module shift_align_16bit
   import serial_deserializer_16bit_pkg::*;
(
   input  logic [WIDTH-1:0]   i_dat,
   input  logic [SHAMT_W-1:0] i_shamt,
   output logic [WIDTH-1:0]   o_dat
);

   // Zero-filling shift moves the top-aligned bits down to the LSBs
   assign o_dat = i_dat >> i_shamt;

endmodule

// File: rtl/serial_deserializer_16bit.sv
// Collects a 1..16 bit serial frame (MSB- or LSB-first) into an LSB-justified word.
// Latency: done pulses the cycle after the last bit is sampled; y updates with it.
// Backpressure: sin_valid low holds the frame indefinitely; start ignored while busy.
module serial_deserializer_16bit #(
   parameter int WIDTH = serial_deserializer_16bit_pkg::WIDTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   serial_deserializer_16bit_if.slave bus
);
   import serial_deserializer_16bit_pkg::*;

   // Full-frame length as a counter-width constant, used for alignment
   localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(WIDTH);

   state_t             r_state;
   logic [WIDTH-1:0]   r_sr;
   logic [WIDTH-1:0]   r_y;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_len;
   logic               r_choice;
   logic               r_done;
   logic               r_busy;

   logic [WIDTH-1:0]   w_sr_next;
   logic [CNT_W-1:0]   w_cnt_next;
   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0]   w_aligned;
   logic [WIDTH-1:0]   w_y_next;

   // Next shift-register value for the latched direction
   always_comb begin
      w_sr_next = r_sr;
      if (r_choice) begin
         w_sr_next = {bus.sin, r_sr[WIDTH-1:1]};
      end else begin
         w_sr_next = {r_sr[WIDTH-2:0], bus.sin};
      end
   end

   assign w_cnt_next = r_cnt + CNT_W'(1);

   // LSB-first frames sit at the top of the register; shift down by 16-len
   assign w_shamt = SHAMT_W'(FULL_LEN - r_len);

   shift_align_16bit u_align (
      .i_dat   (w_sr_next),
      .i_shamt (w_shamt),
      .o_dat   (w_aligned)
   );

   // MSB-first frames already occupy the low len bits and are zero above
   assign w_y_next = r_choice ? w_aligned : w_sr_next;

   // Frame FSM with registered outputs: IDLE -> SHIFT -> DONE -> IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_sr     <= '0;
         r_y      <= '0;
         r_cnt    <= '0;
         r_len    <= '0;
         r_choice <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_choice <= bus.choice;
                  r_len    <= frame_len(bus.amt);
                  r_sr     <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (bus.sin_valid) begin
                  r_sr  <= w_sr_next;
                  r_cnt <= w_cnt_next;
                  if (w_cnt_next == r_len) begin
                     r_y     <= w_y_next;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.y    = r_y;
   assign bus.done = r_done;
   assign bus.busy = r_busy;

endmodule

// File: tb/tb_serial_deserializer_16bit.sv
// Randomized scoreboard bench for the serial deserializer.
// Latency: checks done arrives the cycle after the last consumed bit.
// Backpressure: exercises sin_valid gaps and start pulses while busy.
module tb_serial_deserializer_16bit;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [15:0] q_y[$];
   int          q_cyc[$];
   logic [15:0] held_y = 16'h0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   serial_deserializer_16bit_if u_if ();

   serial_deserializer_16bit #(.WIDTH(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u_if)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on each done pulse, otherwise y must hold
   always @(negedge clk) begin
      if (!reset_n) begin
         held_y = 16'h0;
      end else if (u_if.done) begin
         if (q_y.size() == 0) begin
            check("spurious done", 32'(u_if.done), 32'd0);
         end else begin
            logic [15:0] exp_y;
            int          exp_c;
            exp_y = q_y.pop_front();
            exp_c = (q_cyc.size() != 0) ? q_cyc.pop_front() : -1;
            check("y on done", 32'(u_if.y), 32'(exp_y));
            check("done cycle", 32'(cyc), 32'(exp_c));
            held_y = exp_y;
         end
      end else begin
         check("y hold", 32'(u_if.y), 32'(held_y));
      end
   end

   // Reference: the frame word v is sent MSB-first (choice=0) or LSB-first
   // (choice=1); either way the assembled result must equal v itself.
   task automatic send_frame(input int len, input bit ch, input logic [15:0] v,
                             input int gap_mode, input bit pokes, input int nsend);
      u_if.start     = 1'b1;
      u_if.amt       = 4'(len - 1);
      u_if.choice    = ch;
      u_if.sin       = 1'($urandom);
      u_if.sin_valid = 1'($urandom);
      if (nsend == len) q_y.push_back(v);
      @(posedge clk); #1;
      u_if.start  = 1'b0;
      u_if.amt    = 4'($urandom);
      u_if.choice = 1'($urandom);
      check("busy after start", 32'(u_if.busy), 32'd1);
      for (int i = 0; i < nsend; i++) begin
         int gaps;
         if (gap_mode < 0) gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         else              gaps = gap_mode;
         for (int g = 0; g < gaps; g++) begin
            u_if.sin_valid = 1'b0;
            u_if.sin       = 1'($urandom);
            u_if.start     = pokes ? 1'b1 : 1'b0;
            u_if.amt       = 4'($urandom);
            u_if.choice    = 1'($urandom);
            @(posedge clk); #1;
            u_if.start = 1'b0;
         end
         u_if.sin_valid = 1'b1;
         u_if.sin       = ch ? v[i] : v[len - 1 - i];
         if (i == len - 1) q_cyc.push_back(cyc + 1);
         @(posedge clk); #1;
      end
      if (nsend == len) begin
         // DONE cycle: stray valid bits and start must be ignored
         u_if.sin_valid = 1'b1;
         u_if.sin       = 1'($urandom);
         u_if.start     = pokes;
         @(posedge clk); #1;
         check("busy after frame", 32'(u_if.busy), 32'd0);
      end
      u_if.start     = 1'b0;
      u_if.sin_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         u_if.start     = 1'b0;
         u_if.sin_valid = 1'($urandom);
         u_if.sin       = 1'($urandom);
         @(posedge clk); #1;
      end
      u_if.sin_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.start     = 1'b0;
      u_if.amt       = 4'd0;
      u_if.choice    = 1'b0;
      u_if.sin       = 1'b0;
      u_if.sin_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset y", 32'(u_if.y), 32'd0);
      check("reset done", 32'(u_if.done), 32'd0);
      check("reset busy", 32'(u_if.busy), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Full frames in both directions
      send_frame(16, 1'b0, 16'hF3FF, 0, 1'b0, 16);
      send_frame(16, 1'b1, 16'hF3FF, 0, 1'b0, 16);
      // Short frames
      send_frame(4, 1'b1, 16'h000D, 0, 1'b0, 4);
      send_frame(4, 1'b0, 16'h000B, 0, 1'b0, 4);
      idle_cycles(2);
      // Minimum length with a 5-cycle gap and start pokes while busy
      send_frame(1, 1'b0, 16'h0001, 5, 1'b1, 1);
      idle_cycles(2);

      // Reset after 7 of 16 bits
      send_frame(16, 1'b0, 16'($urandom), 0, 1'b0, 7);
      #3 reset_n = 1'b0;
      #1;
      check("midreset y", 32'(u_if.y), 32'd0);
      check("midreset busy", 32'(u_if.busy), 32'd0);
      check("midreset done", 32'(u_if.done), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      send_frame(16, 1'b0, 16'h0001, 0, 1'b0, 16);
      idle_cycles(1);

      // Back-to-back frames
      send_frame(16, 1'b0, 16'hAAAA, 0, 1'b0, 16);
      send_frame(16, 1'b0, 16'h5555, 0, 1'b0, 16);

      // Randomized frames with gaps, pokes and idle spacing
      for (int f = 0; f < 60; f++) begin
         int          len;
         bit          ch;
         logic [15:0] v;
         len = $urandom_range(1, 16);
         ch  = 1'($urandom);
         v   = 16'($urandom & ((32'd1 << len) - 32'd1));
         send_frame(len, ch, v, -1, 1'($urandom), len);
         idle_cycles($urandom_range(0, 2));
      end

      for (int t = 0; t < 50 && q_y.size() != 0; t++) @(posedge clk);
      check("frames outstanding", 32'(q_y.size()), 32'd0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
